regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port controller for the 32x32 register file. After reset it sequences a clear pass that zeroes all 32 registers. It then shares the single write port (WE3/A3/WD3) between two writeback requesters using round-robin arbitration and a valid/ready handshake. Writes to x0 are suppressed. It sits between the execute/load writeback paths and the register file write port.

## Interface
- No parameters. Register count is fixed at 32, data width at 32, address width at 5.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 (ALU writeback) has a write pending
- req0_addr  in  5  requester 0 destination register
- req0_data  in  32  requester 0 write data
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid  in  1  requester 1 (load writeback) has a write pending
- req1_addr  in  5  requester 1 destination register
- req1_data  in  32  requester 1 write data
- req1_ready  out  1  requester 1 write accepted this cycle
- WE3  out  1  register file write enable (registered)
- A3  out  5  register file write address (registered)
- WD3  out  32  register file write data (registered)
- init_done  out  1  clear pass complete; arbitration active

## Operation
- States:
  - CLEAR: sequences the zeroing pass.
  - RUN: arbitrates requesters.
- Reset (rst=0 at a posedge):
  - state=CLEAR, clear_idx=0, last_grant=1.
  - WE3=0, A3=0, WD3=0, init_done=0.
- CLEAR, one index per cycle:
  - Each posedge registers WE3=1, A3=clear_idx, WD3=0, then clear_idx increments.
  - x0 is included in the clear pass.
  - At the posedge that issues idx 31: state goes to RUN and init_done=1.
  - clear_idx is 5 bits and its wrap is never used.
- RUN grant (combinational from valid and last_grant):
  - Only req0_valid high: grant port 0.
  - Only req1_valid high: grant port 1.
  - Both high: grant the port that is not last_grant.
  - Neither high: no grant.
- reqN_ready = (state==RUN) && grantN. Ready depends on valid. A requester must hold valid/addr/data stable until it sees ready.
- Transfer = reqN_valid && reqN_ready at the posedge. It registers:
  - WE3 = (addrN != 0)
  - A3 = addrN
  - WD3 = dataN
  - last_grant = N
- No transfer in RUN: WE3=0. A3 and WD3 hold their previous values.
- An x0 write is accepted (ready high, last_grant updates) but produces no WE3 pulse.
- Both ready outputs are 0 in CLEAR and at most one is high in RUN.

## Timing
- Latency: transfer accepted at posedge N puts WE3/A3/WD3 valid during cycle N+1. The register file captures the data at posedge N+1.
- Throughput is one write per cycle, sustained, with no bubbles between back-to-back grants.
- The clear pass asserts WE3 for exactly 32 consecutive cycles, starting in the cycle after the first posedge with rst=1.
- init_done rises in the same cycle as the last clear write (A3=31). The first requester acceptance is possible at the posedge after that.
- Under persistent contention the ports alternate 0,1,0,1,... Starvation bound: one cycle.
- The registered WE3/A3/WD3 are the only write-in-flight indication. Downstream forwarding logic uses them to cover the one-cycle write-to-read window.
- Reset mid-operation: any in-flight transfer is dropped, outputs return to reset values on that edge, and the clear pass restarts from idx 0 once rst returns to 1. Requesters must re-present their pending writes after init_done.
- Reset mid-CLEAR behaves the same way: restart from idx 0.

## Test plan
- Release reset with both requesters valid → ready stays 0 for 32 cycles. WE3=1 with A3=0..31 and WD3=0 on consecutive cycles. init_done=1 with A3=31. Register file reads all 0 afterwards.
- Single requester: req0 writes addr 5, data 0xDEADBEEF → req0_ready=1 in the same cycle. Next cycle WE3=1, A3=5, WD3=0xDEADBEEF. Following cycle WE3=0.
- Contention: both valid for 6 cycles with distinct addrs 1..6, first grant after reset → grant order 0,1,0,1,0,1. WE3 stays high for 6 cycles. Each requester's data lands at its own addr.
- x0 write: req1 addr 0, data 0x12345678 → req1_ready=1 but WE3 stays 0. last_grant=1, so the next contended cycle grants port 0.
- Reset asserted during RUN with req0 accepted on the same edge → WE3=0 next cycle and the write is not performed. After reset release the 32-cycle clear repeats and init_done re-rises.
- Reset asserted at clear idx 17 → outputs go to reset values. After release the clear restarts at A3=0 and completes 32 writes.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register file: zeroes every register after
// reset, then round-robins the single write port between two writeback requesters.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        init_done
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  clearIdx_q, clearIdx_d;
  logic        lastGrant_q, lastGrant_d;
  logic        we_q, we_d;
  logic [4:0]  a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic        initDone_q, initDone_d;
  logic        grant0, grant1;

  // Under contention the port that did not win last time gets the grant.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || lastGrant_q);
    grant1 = req1_valid && (!req0_valid || !lastGrant_q);
  end

  assign req0_ready = (state_q == RUN) && grant0;
  assign req1_ready = (state_q == RUN) && grant1;

  always_comb begin
    state_d     = state_q;
    clearIdx_d  = clearIdx_q;
    lastGrant_d = lastGrant_q;
    we_d        = 1'b0;
    a_d         = a_q;
    wd_d        = wd_q;
    initDone_d  = initDone_q;
    case (state_q)
      CLEAR: begin
        we_d       = 1'b1;
        a_d        = clearIdx_q;
        wd_d       = 32'd0;
        clearIdx_d = clearIdx_q + 5'd1;
        if (clearIdx_q == 5'd31) begin
          state_d    = RUN;
          initDone_d = 1'b1;
        end
      end
      RUN: begin
        // x0 writes are accepted but never raise the write enable.
        if (req0_valid && req0_ready) begin
          we_d        = (req0_addr != 5'd0);
          a_d         = req0_addr;
          wd_d        = req0_data;
          lastGrant_d = 1'b0;
        end else if (req1_valid && req1_ready) begin
          we_d        = (req1_addr != 5'd0);
          a_d         = req1_addr;
          wd_d        = req1_data;
          lastGrant_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= CLEAR;
      clearIdx_q  <= 5'd0;
      lastGrant_q <= 1'b1;
      we_q        <= 1'b0;
      a_q         <= 5'd0;
      wd_q        <= 32'd0;
      initDone_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clearIdx_q  <= clearIdx_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      a_q         <= a_d;
      wd_q        <= wd_d;
      initDone_q  <= initDone_d;
    end
  end

  assign WE3       = we_q;
  assign A3        = a_q;
  assign WD3       = wd_q;
  assign init_done = initDone_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: the driver queues expected register-file
// writes, a negedge monitor pops one entry per WE3 pulse.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        init_done;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        initDone;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int compareCount = 0;
  int failCount = 0;
  logic modelLast;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write-port pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (WE3 === 1'b1) begin
      if (sbQ.size() == 0) begin
        compareCount++;
        failCount++;
        $display("[TB] FAIL unexpected_we3: got A3=%0d WD3=0x%0h expected no write at %0t", A3, WD3, $time);
      end else begin
        sbEntry_t e;
        e = sbQ.pop_front();
        checkOutput("wb_addr", 32'(A3), 32'(e.addr));
        checkOutput("wb_data", WD3, e.data);
        checkOutput("wb_init_done", 32'(init_done), 32'(e.initDone));
      end
    end
    if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL dual_ready: got both ready expected at most one at %0t", $time);
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && sbQ.size() != 0; i++) tick();
    checkOutput("drain_pending", 32'(sbQ.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_we3"}, 32'(WE3), 32'd0);
    checkOutput({tag, "_a3"}, 32'(A3), 32'd0);
    checkOutput({tag, "_wd3"}, WD3, 32'd0);
    checkOutput({tag, "_init_done"}, 32'(init_done), 32'd0);
    checkOutput({tag, "_ready0"}, 32'(req0_ready), 32'd0);
    checkOutput({tag, "_ready1"}, 32'(req1_ready), 32'd0);
  endtask

  // Releases reset and expects the full 32-entry clear pass with readies held low.
  task automatic releaseReset();
    for (int i = 0; i < 32; i++) sbQ.push_back('{addr: 5'(i), data: 32'd0, initDone: (i == 31)});
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      checkOutput("clear_ready0", 32'(req0_ready), 32'd0);
      checkOutput("clear_ready1", 32'(req1_ready), 32'd0);
      tick();
    end
    modelLast = 1'b1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               output logic g0, output logic g1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    g0 = v0 && (!v1 || modelLast);
    g1 = v1 && !g0;
    #1;
    checkOutput("ready0", 32'(req0_ready), 32'(g0));
    checkOutput("ready1", 32'(req1_ready), 32'(g1));
    if (g0 && a0 != 5'd0) sbQ.push_back('{addr: a0, data: d0, initDone: 1'b1});
    if (g1 && a1 != 5'd0) sbQ.push_back('{addr: a1, data: d1, initDone: 1'b1});
    if (g0) modelLast = 1'b0;
    if (g1) modelLast = 1'b1;
    tick();
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic g0, g1;
    logic [4:0] p0 [4];
    logic [4:0] p1 [3];
    int i0, i1;
    p0 = '{5'd1, 5'd3, 5'd5, 5'd7};
    p1 = '{5'd2, 5'd4, 5'd6};
    modelLast = 1'b1;

    // Reset with both requesters already waiting.
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h2222_2222;
    repeat (3) tick();
    checkResetOutputs("reset");
    releaseReset();
    idle();
    drain();

    // Contention: port 0 queues 1,3,5,7 and port 1 queues 2,4,6; grants must alternate.
    i0 = 0; i1 = 0;
    for (int n = 0; n < 20 && (i0 < 4 || i1 < 3); n++) begin
      logic v0, v1;
      logic [4:0] a0, a1;
      v0 = (i0 < 4); v1 = (i1 < 3);
      a0 = 5'd0; a1 = 5'd0;
      if (v0) a0 = p0[i0];
      if (v1) a1 = p1[i1];
      applyStimulus(v0, a0, 32'hA0A0_0000 | 32'(a0), v1, a1, 32'hB1B1_0000 | 32'(a1), g0, g1);
      if (g0) i0++;
      if (g1) i1++;
    end
    idle();
    drain();

    // Single requester, then confirm the pulse is exactly one cycle wide.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, g0, g1);
    idle();
    checkOutput("single_we3", 32'(WE3), 32'd1);
    checkOutput("single_a3", 32'(A3), 32'd5);
    checkOutput("single_wd3", WD3, 32'hDEAD_BEEF);
    tick();
    checkOutput("single_we3_off", 32'(WE3), 32'd0);
    drain();

    // x0 write by port 1: accepted, no pulse, and port 0 wins the next contention.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678, g0, g1);
    idle();
    checkOutput("x0_we3", 32'(WE3), 32'd0);
    applyStimulus(1'b1, 5'd8, 32'h0808_0808, 1'b1, 5'd9, 32'h0909_0909, g0, g1);
    checkOutput("x0_next_grant0", 32'(g0), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0909_0909, g0, g1);
    idle();
    drain();

    // Reset during RUN on the same edge as a port 0 acceptance drops that write.
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hCAFE_F00D;
    tick();
    checkResetOutputs("run_reset");
    idle();
    tick();
    releaseReset();
    drain();

    // Reset arriving on the edge that would issue clear index 17.
    rst = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) sbQ.push_back('{addr: 5'(i), data: 32'd0, initDone: 1'b0});
    rst = 1'b1;
    repeat (17) tick();
    rst = 1'b0;
    tick();
    checkResetOutputs("clear_reset");
    checkOutput("clear_reset_pending", 32'(sbQ.size()), 32'd0);
    tick();
    releaseReset();
    drain();

    // Operation resumes after the restarted clear.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h0BAD_C0DE, g0, g1);
    idle();
    checkOutput("final_we3", 32'(WE3), 32'd1);
    checkOutput("final_a3", 32'(A3), 32'd20);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
